datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
- Round-robin arbiter and response stage sitting directly upstream of the data memory.
- Collects load/store requests from N_LANES GPU lanes over valid/ready handshakes.
- Issues exactly one access per cycle to the single-port data memory, whose read is combinational and write lands on posedge clk.
- Registers read data back to the winning lane with a one-cycle response pulse.

Parameters:
N_LANES, 4, number of requesting lanes (2..8)
ADDR_W, 8, address width, equals DATAMEM_ADDR_WIDTH
DATA_W, 8, data word width, equals DATA_WORD_LENGTH

Ports:
clk  input  1  single clock, all state on posedge
reset_n  input  1  synchronous active-low reset, sampled on posedge clk
req_valid  input  N_LANES  per-lane request valid
req_we  input  N_LANES  per-lane 1=store, 0=load
req_addr  input  N_LANES*ADDR_W  lane i in bits [i*ADDR_W +: ADDR_W]
req_wdata  input  N_LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W]
req_ready  output  N_LANES  one-hot grant; handshake = valid & ready
resp_valid  output  N_LANES  one-cycle pulse, cycle after handshake
resp_rdata  output  N_LANES*DATA_W  per-lane registered load data
mem_we  output  1  to datamem MemWrite
mem_addr  output  ADDR_W  to datamem Address
mem_wdata  output  DATA_W  to datamem WriteData
mem_rdata  input  DATA_W  from datamem ReadData (combinational)
busy  output  1  1 when any req_valid is high and not in reset

Behaviour:
- State: rr_ptr (clog2(N_LANES) bits), resp_valid, and resp_rdata registers.
- Reset (reset_n=0 at posedge): rr_ptr=0, resp_valid=0, resp_rdata=0.
- Outputs while reset_n=0, combinational: req_ready=0, mem_we=0, busy=0. No store may reach memory while reset is asserted, including mid-stream.
- Grant (combinational): g = first lane i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap modulo N_LANES.
  - If such a lane exists: req_ready = one-hot(g).
  - If none exists: req_ready=0.
- Memory drive:
  - mem_addr = req_addr[g] and mem_wdata = req_wdata[g] when a grant exists, else 0.
  - mem_we = granted & req_we[g].
- On a handshake at posedge:
  - rr_ptr <= (g+1) mod N_LANES.
  - resp_valid <= one-hot(g).
  - For a load: resp_rdata[g] <= mem_rdata, sampled in the grant cycle. Latency is 1 cycle from handshake to resp_valid.
  - For a store: resp_valid still pulses as an acknowledge; resp_rdata[g] holds its previous value.
- With no handshake: resp_valid <= 0 and rr_ptr holds.
- resp_rdata of lanes that were not granted always hold.
- Lane rules: a lane holds req_valid, req_we, req_addr and req_wdata stable until its ready. Lanes may keep req_valid high back-to-back.
- Fairness: with all lanes continuously requesting, grants rotate 0,1,...,N-1,0. No lane waits more than N_LANES-1 cycles.
- Ordering: a store then a load to the same address from any lanes in consecutive cycles returns the new data, because the memory write lands before the next combinational read.
- Only one access per cycle, so a single-port read/write conflict cannot occur.
- Address truncation is done inside datamem; the arbiter passes the full ADDR_W.
- Reset mid-operation:
  - Pending requests are not granted during reset.
  - The first grant after reset starts the scan at lane 0.
  - Any resp_valid pulse due in the reset cycle is suppressed.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all req_valid=1 and req_we=1 -> req_ready=0, mem_we=0, resp_valid=0, resp_rdata=0, and memory contents unchanged.
- Single load: lane 2 requests a load at addr 0x05, memory[5]=0xA7 -> in the same cycle req_ready=4'b0100 and mem_addr=0x05; next cycle resp_valid=4'b0100 and lane 2 rdata=0xA7 (held thereafter).
- Round-robin: all 4 lanes load continuously from rr_ptr=0 -> grants 0,1,2,3,0,1 on successive cycles; each resp_valid is one-hot and one cycle behind its grant.
- Wrap and skip: rr_ptr=3, only lanes 1 and 3 valid -> lane 3 is granted first, then lane 1; rr_ptr ends at 2.
- Store then load: lane 0 stores 0x3C to 0x10, then lane 1 loads 0x10 on the next cycle -> lane 1 rdata=0x3C; lane 0 gets an ack pulse and its rdata is unchanged.
- Reset mid-stream: assert reset_n=0 in the cycle after lane 1's handshake while lanes 2 and 3 are pending -> no resp pulse and no write in that cycle; after release, lane 2 is granted first (scan from 0, lanes 0 and 1 idle).

Source files
------------

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter between N_LANES load/store lanes and a single-port data memory.
// One access per cycle; load data and per-lane ack pulses are registered back to the lanes.
module datamem_arbiter #(
    parameter int N_LANES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_LANES-1:0]          req_valid,
    input  logic [N_LANES-1:0]          req_we,
    input  logic [N_LANES*ADDR_W-1:0]   req_addr,
    input  logic [N_LANES*DATA_W-1:0]   req_wdata,
    output logic [N_LANES-1:0]          req_ready,
    output logic [N_LANES-1:0]          resp_valid,
    output logic [N_LANES*DATA_W-1:0]   resp_rdata,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);
    localparam int PTR_W = $clog2(N_LANES);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_LANES - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   g;
    logic               granted;
    logic               grant_ok;
    logic [N_LANES-1:0] resp_valid_q;

    // First valid lane at or after rr_ptr, wrapping modulo N_LANES.
    always_comb begin
        granted  = 1'b0;
        g        = '0;
        scan_idx = '0;
        for (int k = 0; k < N_LANES; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % N_LANES);
            if (!granted && req_valid[scan_idx]) begin
                granted = 1'b1;
                g       = scan_idx;
            end
        end
    end

    assign grant_ok = granted & reset_n;

    always_comb begin
        req_ready = '0;
        if (grant_ok) begin
            req_ready[g] = 1'b1;
        end
    end

    // req_ready is one-hot or zero, so this mux yields zeros when nothing is granted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (req_ready[i]) begin
                mem_we    = req_we[i];
                mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            resp_valid_q <= '0;
            resp_rdata   <= '0;
        end else begin
            resp_valid_q <= req_ready;
            if (grant_ok) begin
                rr_ptr <= (g == LAST) ? '0 : g + 1'b1;
            end
            for (int i = 0; i < N_LANES; i++) begin
                if (req_ready[i] && !req_we[i]) begin
                    resp_rdata[i*DATA_W +: DATA_W] <= mem_rdata;
                end
            end
        end
    end

    // A pulse registered just before reset asserts must not be seen during reset.
    assign resp_valid = resp_valid_q & {N_LANES{reset_n}};
    assign busy       = reset_n & (|req_valid);

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a behavioural single-port data memory.
module tb_datamem_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_we;
    logic [N*8-1:0] req_addr;
    logic [N*8-1:0] req_wdata;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [N*8-1:0] resp_rdata;
    logic           mem_we;
    logic [7:0]     mem_addr;
    logic [7:0]     mem_wdata;
    logic [7:0]     mem_rdata;
    logic           busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [0:255];

    datamem_arbiter #(.N_LANES(N), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    function automatic logic [7:0] lane_rdata(input int lane);
        return resp_rdata[lane*8 +: 8];
    endfunction

    task automatic set_lane(input int lane, input logic v, input logic we,
                            input logic [7:0] addr, input logic [7:0] wdata);
        req_valid[lane]         = v;
        req_we[lane]            = we;
        req_addr[lane*8 +: 8]   = addr;
        req_wdata[lane*8 +: 8]  = wdata;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] pre [4];
        pre = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 1'b1, 8'(8'h60 + i), 8'hFF);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready_t0: got %b expected %b", req_ready, 4'b0000); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we_t0: got %b expected 0", mem_we); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b expected %b", req_ready, 4'b0000); end
            n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
            n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_resp_valid: got %b expected %b", resp_valid, 4'b0000); end
            n_cmp++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_resp_rdata: got %h expected %h", resp_rdata, 32'h0); end
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (mem[8'h60 + i] !== pre[i]) begin n_err++; $display("FAIL rst_mem_intact[%0d]: got %h expected %h", i, mem[8'h60 + i], pre[i]); end
        end
        req_valid = '0;
        reset_n   = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [6];
        int         exp_l [6];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_l = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 1'b0, 8'(8'h20 + i), 8'h00);
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++; if (req_ready !== exp_g[c]) begin n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, exp_g[c]); end
            n_cmp++; if (mem_addr !== 8'(8'h20 + exp_l[c])) begin n_err++; $display("FAIL rr_addr[%0d]: got %h expected %h", c, mem_addr, 8'(8'h20 + exp_l[c])); end
            step();
            n_cmp++; if (resp_valid !== exp_g[c]) begin n_err++; $display("FAIL rr_resp[%0d]: got %b expected %b", c, resp_valid, exp_g[c]); end
            n_cmp++; if (lane_rdata(exp_l[c]) !== 8'(8'h50 + exp_l[c])) begin n_err++; $display("FAIL rr_rdata[%0d]: got %h expected %h", c, lane_rdata(exp_l[c]), 8'(8'h50 + exp_l[c])); end
        end
        req_valid = '0;
    endtask

    task automatic test_single_load;
        set_lane(2, 1'b1, 1'b0, 8'h05, 8'h00);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL load_ready: got %b expected %b", req_ready, 4'b0100); end
        n_cmp++; if (mem_addr !== 8'h05) begin n_err++; $display("FAIL load_addr: got %h expected %h", mem_addr, 8'h05); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL load_we: got %b expected 0", mem_we); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b expected 1", busy); end
        step();
        req_valid = '0;
        n_cmp++; if (resp_valid !== 4'b0100) begin n_err++; $display("FAIL load_resp: got %b expected %b", resp_valid, 4'b0100); end
        n_cmp++; if (lane_rdata(2) !== 8'hA7) begin n_err++; $display("FAIL load_rdata: got %h expected %h", lane_rdata(2), 8'hA7); end
        step();
        n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL load_resp_clear: got %b expected %b", resp_valid, 4'b0000); end
        n_cmp++; if (lane_rdata(2) !== 8'hA7) begin n_err++; $display("FAIL load_rdata_hold: got %h expected %h", lane_rdata(2), 8'hA7); end
    endtask

    task automatic test_wrap_skip;
        set_lane(1, 1'b1, 1'b0, 8'h25, 8'h00);
        set_lane(3, 1'b1, 1'b0, 8'h24, 8'h00);
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_first: got %b expected %b", req_ready, 4'b1000); end
        step();
        req_valid[3] = 1'b0;
        n_cmp++; if (resp_valid !== 4'b1000) begin n_err++; $display("FAIL wrap_resp3: got %b expected %b", resp_valid, 4'b1000); end
        n_cmp++; if (lane_rdata(3) !== 8'h64) begin n_err++; $display("FAIL wrap_rdata3: got %h expected %h", lane_rdata(3), 8'h64); end
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_second: got %b expected %b", req_ready, 4'b0010); end
        step();
        req_valid = '0;
        n_cmp++; if (resp_valid !== 4'b0010) begin n_err++; $display("FAIL wrap_resp1: got %b expected %b", resp_valid, 4'b0010); end
        n_cmp++; if (lane_rdata(1) !== 8'h65) begin n_err++; $display("FAIL wrap_rdata1: got %h expected %h", lane_rdata(1), 8'h65); end
        // All lanes valid for a moment only: grant reveals rr_ptr without a handshake.
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_ptr_end: got %b expected %b", req_ready, 4'b0100); end
        req_valid = '0;
    endtask

    task automatic test_store_then_load;
        set_lane(0, 1'b1, 1'b1, 8'h10, 8'h3C);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL st_ready: got %b expected %b", req_ready, 4'b0001); end
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL st_we: got %b expected 1", mem_we); end
        n_cmp++; if (mem_wdata !== 8'h3C) begin n_err++; $display("FAIL st_wdata: got %h expected %h", mem_wdata, 8'h3C); end
        step();
        req_valid[0] = 1'b0;
        set_lane(1, 1'b1, 1'b0, 8'h10, 8'h00);
        n_cmp++; if (resp_valid !== 4'b0001) begin n_err++; $display("FAIL st_ack: got %b expected %b", resp_valid, 4'b0001); end
        n_cmp++; if (lane_rdata(0) !== 8'h50) begin n_err++; $display("FAIL st_rdata_hold: got %h expected %h", lane_rdata(0), 8'h50); end
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ld_ready: got %b expected %b", req_ready, 4'b0010); end
        step();
        req_valid = '0;
        n_cmp++; if (resp_valid !== 4'b0010) begin n_err++; $display("FAIL ld_resp: got %b expected %b", resp_valid, 4'b0010); end
        n_cmp++; if (lane_rdata(1) !== 8'h3C) begin n_err++; $display("FAIL ld_new_data: got %h expected %h", lane_rdata(1), 8'h3C); end
        n_cmp++; if (lane_rdata(0) !== 8'h50) begin n_err++; $display("FAIL st_rdata_hold2: got %h expected %h", lane_rdata(0), 8'h50); end
    endtask

    task automatic test_reset_mid;
        set_lane(1, 1'b1, 1'b0, 8'h30, 8'h00);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_ready1: got %b expected %b", req_ready, 4'b0010); end
        step();
        req_valid[1] = 1'b0;
        set_lane(2, 1'b1, 1'b1, 8'h40, 8'hEE);
        set_lane(3, 1'b1, 1'b1, 8'h41, 8'hDD);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 4'b0000) begin n_err++; $display("FAIL mid_resp_suppressed: got %b expected %b", resp_valid, 4'b0000); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_ready_rst: got %b expected %b", req_ready, 4'b0000); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL mid_we_rst: got %b expected 0", mem_we); end
        step();
        reset_n = 1'b1;
        #1;
        n_cmp++; if (mem[8'h40] !== 8'h00) begin n_err++; $display("FAIL mid_no_write40: got %h expected %h", mem[8'h40], 8'h00); end
        n_cmp++; if (mem[8'h41] !== 8'h00) begin n_err++; $display("FAIL mid_no_write41: got %h expected %h", mem[8'h41], 8'h00); end
        n_cmp++; if (lane_rdata(1) !== 8'h00) begin n_err++; $display("FAIL mid_rdata_cleared: got %h expected %h", lane_rdata(1), 8'h00); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_first_after: got %b expected %b", req_ready, 4'b0100); end
        n_cmp++; if (mem_addr !== 8'h40) begin n_err++; $display("FAIL mid_addr_after: got %h expected %h", mem_addr, 8'h40); end
        step();
        req_valid[2] = 1'b0;
        n_cmp++; if (resp_valid !== 4'b0100) begin n_err++; $display("FAIL mid_resp2: got %b expected %b", resp_valid, 4'b0100); end
        n_cmp++; if (mem[8'h40] !== 8'hEE) begin n_err++; $display("FAIL mid_write40: got %h expected %h", mem[8'h40], 8'hEE); end
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mid_second_after: got %b expected %b", req_ready, 4'b1000); end
        step();
        req_valid = '0;
        n_cmp++; if (resp_valid !== 4'b1000) begin n_err++; $display("FAIL mid_resp3: got %b expected %b", resp_valid, 4'b1000); end
        n_cmp++; if (mem[8'h41] !== 8'hDD) begin n_err++; $display("FAIL mid_write41: got %h expected %h", mem[8'h41], 8'hDD); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h05] = 8'hA7;
        for (int i = 0; i < N; i++) mem[8'h20 + i] = 8'(8'h50 + i);
        mem[8'h24] = 8'h64;
        mem[8'h25] = 8'h65;
        mem[8'h30] = 8'h99;
        mem[8'h60] = 8'h11;
        mem[8'h61] = 8'h22;
        mem[8'h62] = 8'h33;
        mem[8'h63] = 8'h44;
        reset_n   = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        test_reset();
        test_round_robin();
        test_single_load();
        test_wrap_skip();
        test_store_then_load();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
